// File: rtl/max1452_seq_programmer_if.sv
// Control/status bundle between a host and the MAX1452 configuration sequencer.
// Signal prefixes are from the sequencer's point of view: i_* into it, o_* out of it.
interface max1452_seq_programmer_if #(
    parameter int unsigned AW     = 5,
    parameter int unsigned NUM_CH = 8,
    parameter int unsigned CW     = 3
);
    logic              i_cfg_we;
    logic [AW-1:0]     i_cfg_addr;
    logic [7:0]        i_cfg_wdata;
    logic [AW:0]       i_seq_len;
    logic [NUM_CH-1:0] i_ch_mask;
    logic              i_start;
    logic              i_abort;
    logic              o_rs_tx;
    logic [CW-1:0]     o_ch_sel;
    logic              o_unlock;
    logic              o_busy;
    logic              o_done;

    modport slave (
        input  i_cfg_we, i_cfg_addr, i_cfg_wdata, i_seq_len, i_ch_mask, i_start, i_abort,
        output o_rs_tx, o_ch_sel, o_unlock, o_busy, o_done
    );

    modport master (
        output i_cfg_we, i_cfg_addr, i_cfg_wdata, i_seq_len, i_ch_mask, i_start, i_abort,
        input  o_rs_tx, o_ch_sel, o_unlock, o_busy, o_done
    );
endinterface

// File: rtl/max1452_seq_programmer.sv
// MAX1452 configuration sequencer: for each channel set in the mask, selects the mux
// channel, raises UNLOCK, waits a settle time and streams the loadable byte table out
// as 8N1 UART frames with an idle gap between bytes.
module max1452_seq_programmer #(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned DEPTH        = 32,
    parameter int unsigned AW           = 5,
    parameter int unsigned NUM_CH       = 8,
    parameter int unsigned CW           = 3,
    parameter int unsigned GAP_CLKS     = 5000,
    parameter int unsigned SETTLE_CLKS  = 50000
) (
    input  logic                          clk,
    input  logic                          rst_n,
    max1452_seq_programmer_if.slave       bus
);
    localparam int unsigned CMAX0 = (CLKS_PER_BIT > GAP_CLKS) ? CLKS_PER_BIT : GAP_CLKS;
    localparam int unsigned CMAX  = (CMAX0 > SETTLE_CLKS) ? CMAX0 : SETTLE_CLKS;
    localparam int unsigned CNTW  = $clog2(CMAX + 1);

    typedef enum logic [2:0] {
        ST_IDLE, ST_SETTLE, ST_LOAD, ST_SEND, ST_GAP, ST_NEXT_CH, ST_FIN
    } state_t;

    state_t            r_state, w_state_nx;
    logic [CNTW-1:0]   r_cnt;
    logic [3:0]        r_bit;
    logic [AW-1:0]     r_idx;
    logic [AW:0]       r_len;
    logic [NUM_CH-1:0] r_mask;
    logic [CW-1:0]     r_ch;
    logic [9:0]        r_shift;
    logic [7:0]        r_mem [DEPTH];

    logic              w_go, w_bit_end, w_last_byte, w_addr_ok;
    logic              w_rs_tx, w_unlock, w_busy, w_done;
    logic [AW:0]       w_len_clamp;
    logic [NUM_CH-1:0] w_mask_rem;

    function automatic logic [CW-1:0] f_lowest(input logic [NUM_CH-1:0] m);
        f_lowest = '0;
        for (int unsigned i = NUM_CH; i > 0; i--) begin
            if (m[i-1]) f_lowest = CW'(i - 1);
        end
    endfunction

    generate
        if (DEPTH < (2 ** AW)) begin : g_addr_chk
            assign w_addr_ok = ({1'b0, bus.i_cfg_addr} < (AW+1)'(DEPTH));
        end else begin : g_addr_full
            assign w_addr_ok = 1'b1;
        end
    endgenerate

    assign w_len_clamp = (bus.i_seq_len > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : bus.i_seq_len;
    assign w_go        = bus.i_start && !bus.i_abort && (bus.i_seq_len != '0) && (bus.i_ch_mask != '0);
    assign w_bit_end   = (r_cnt == CNTW'(CLKS_PER_BIT - 1));
    assign w_last_byte = (({1'b0, r_idx} + 1'b1) >= r_len);
    assign w_mask_rem  = r_mask & ~(NUM_CH'(1) << r_ch);

    // Phase register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nx;
    end

    // Next-phase decode and state-derived outputs; abort overrides every transition.
    always_comb begin
        w_state_nx = r_state;
        w_rs_tx    = 1'b1;
        w_unlock   = 1'b0;
        w_busy     = 1'b1;
        w_done     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_busy = 1'b0;
                if (bus.i_start) w_state_nx = w_go ? ST_SETTLE : ST_FIN;
            end
            ST_SETTLE: begin
                w_unlock = 1'b1;
                if (r_cnt == CNTW'(SETTLE_CLKS - 1)) w_state_nx = ST_LOAD;
            end
            ST_LOAD: begin
                w_unlock   = 1'b1;
                w_state_nx = ST_SEND;
            end
            ST_SEND: begin
                w_unlock = 1'b1;
                w_rs_tx  = r_shift[0];
                if (w_bit_end && (r_bit == 4'd9)) w_state_nx = w_last_byte ? ST_NEXT_CH : ST_GAP;
            end
            ST_GAP: begin
                w_unlock = 1'b1;
                if (r_cnt == CNTW'(GAP_CLKS - 1)) w_state_nx = ST_LOAD;
            end
            ST_NEXT_CH: begin
                w_state_nx = (w_mask_rem != '0) ? ST_SETTLE : ST_FIN;
            end
            ST_FIN: begin
                w_busy     = 1'b0;
                w_done     = 1'b1;
                w_state_nx = ST_IDLE;
            end
            default: w_state_nx = ST_IDLE;
        endcase
        if (bus.i_abort) w_state_nx = ST_IDLE;
    end

    // Phase counter, frame shifter, byte index and channel bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_bit   <= '0;
            r_idx   <= '0;
            r_len   <= '0;
            r_mask  <= '0;
            r_ch    <= '0;
            r_shift <= '1;
        end else begin
            r_cnt <= (w_state_nx == r_state) ? r_cnt + 1'b1 : '0;
            case (r_state)
                ST_IDLE: begin
                    r_cnt <= '0;
                    r_idx <= '0;
                    if (w_go) begin
                        r_len  <= w_len_clamp;
                        r_mask <= bus.i_ch_mask;
                        r_ch   <= f_lowest(bus.i_ch_mask);
                    end
                end
                ST_LOAD: begin
                    r_shift <= {1'b1, r_mem[r_idx], 1'b0};
                    r_bit   <= '0;
                end
                // Stop bit is shifted in from the top so the line idles high after the frame.
                ST_SEND: if (w_bit_end) begin
                    r_cnt   <= '0;
                    r_bit   <= r_bit + 1'b1;
                    r_shift <= {1'b1, r_shift[9:1]};
                end
                ST_GAP: if (w_state_nx == ST_LOAD) r_idx <= r_idx + 1'b1;
                ST_NEXT_CH: begin
                    r_idx  <= '0;
                    r_mask <= w_mask_rem;
                    if (w_mask_rem != '0) r_ch <= f_lowest(w_mask_rem);
                end
                default: ;
            endcase
        end
    end

    // Byte table: host writes only while idle; contents survive reset.
    always_ff @(posedge clk) begin
        if (bus.i_cfg_we && !w_busy && w_addr_ok) r_mem[bus.i_cfg_addr] <= bus.i_cfg_wdata;
    end

    assign bus.o_rs_tx  = w_rs_tx;
    assign bus.o_ch_sel = r_ch;
    assign bus.o_unlock = w_unlock;
    assign bus.o_busy   = w_busy;
    assign bus.o_done   = w_done;
endmodule
